// File: rtl/regfile_scoreboard.sv
// Multi-port register file with two write ports, same-cycle write-to-read bypass
// and a per-register busy scoreboard that holds back consumers of in-flight loads.

module rf_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              busy_bit,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  logic hit0, hit1, nz;

  assign nz   = (addr != '0);
  assign hit1 = we1 && (wa1 == addr);
  assign hit0 = we0 && (wa0 == addr);

  // Bypass order matches write priority: the load port wins over the ALU port.
  always_comb begin
    data = '0;
    if (nz) begin
      if (hit1)      data = wd1;
      else if (hit0) data = wd0;
      else           data = stored;
    end
  end

  // A release landing this cycle is already visible through the bypass.
  assign busy = busy_bit & ~hit1 & nz;
endmodule

module regfile_scoreboard #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                NUM_RD  = 2,
  parameter int                SP_IDX  = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h800
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              rel_ok, rsv_ok, inc, dec;

  // Entry 0 is held at zero and never written, so it reads as zero for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      if (SP_IDX != 0) regs[SP_IDX] <= SP_INIT;
    end else begin
      if (we0 && wa0 != '0) regs[wa0] <= wd0;
      if (we1 && wa1 != '0) regs[wa1] <= wd1;
    end
  end

  assign rel_ok = we1 && (wa1 != '0);
  assign rsv_ok = rsv_en && (rsv_addr != '0);

  // Clear then set: a register released and re-reserved together stays busy.
  always_comb begin
    busy_nxt = busy;
    if (rel_ok) busy_nxt[wa1]      = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
  end

  assign inc = rsv_ok && !busy[rsv_addr];
  assign dec = rel_ok && busy[wa1] && !(rsv_ok && rsv_addr == wa1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    end
  end

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = rd_addr[i*ADDR_W +: ADDR_W];
      rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
        .addr    (a),
        .stored  (regs[a]),
        .busy_bit(busy[a]),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .data    (rd_data[i*DATA_W +: DATA_W]),
        .busy    (rd_busy[i])
      );
    end
  endgenerate

  assign stall = |(rd_en & rd_busy);
endmodule
